// File: rtl/user_mem_64x8_pkg.sv
// ---------------------------------------------------------------------------
// user_mem_pkg
// Shared constants and types for the 8 x 8-bit pad-driven user memory.
//   - Pad index constants for the mprj_io bits the block uses.
//   - Default word/address widths and synchroniser depth.
//   - Operation encoding and the decode helper used by the top block.
// ---------------------------------------------------------------------------
package user_mem_pkg;

    localparam int PAD_W              = 38;

    // Pad positions inside io_in / io_out / io_oeb
    localparam int RD_EN_PIN          = 0;
    localparam int WR_EN_PIN          = 3;
    localparam int ADDR_LSB           = 5;
    localparam int DATA_LSB           = 8;
    localparam int RDATA_LSB          = 16;
    localparam int RVALID_PIN         = 24;

    // Default geometry: 8 words of 8 bits, two-flop synchroniser
    localparam int DEFAULT_DATA_W     = 8;
    localparam int DEFAULT_ADDR_W     = 3;
    localparam int DEFAULT_SYNC_STAGE = 2;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_READ    = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_t;

    // Maps the synchronised enables onto the operation performed this cycle.
    function automatic op_t decode_op(input logic rd, input logic wr);
        op_t op;
        case ({rd, wr})
            2'b01:   op = OP_WRITE;
            2'b10:   op = OP_READ;
            2'b11:   op = OP_ILLEGAL;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/user_mem_64x8_if.sv
// ---------------------------------------------------------------------------
// user_mem_64x8_if
// Bundle of the Caravel mprj_io pad signals seen by the user memory.
//   io_in  : pad inputs (driven by the pad ring / test harness)
//   io_out : pad output values
//   io_oeb : pad output enables, active-low
// Modports:
//   master : the pad side, drives io_in and observes io_out/io_oeb
//   slave  : the user block, consumes io_in and drives io_out/io_oeb
// ---------------------------------------------------------------------------
interface user_mem_64x8_if;
    import user_mem_pkg::*;

    logic [PAD_W-1:0] io_in;
    logic [PAD_W-1:0] io_out;
    logic [PAD_W-1:0] io_oeb;

    modport master (
        output io_in,
        input  io_out,
        input  io_oeb
    );

    modport slave (
        input  io_in,
        output io_out,
        output io_oeb
    );

endinterface

// File: rtl/user_mem_64x8_pad_sync.sv
// ---------------------------------------------------------------------------
// pad_sync
// Multi-bit, N-stage flip-flop synchroniser for asynchronous pad inputs.
// Each bit is synchronised independently; consumers must tolerate skew
// between bits of a multi-bit field (the pads are held for many cycles).
// Ports:
//   clk  : destination clock
//   srst : synchronous active-high clear of every stage
//   d    : asynchronous input bits
//   q    : synchronised output (last stage)
// ---------------------------------------------------------------------------
module pad_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_reg [STAGES];

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/user_mem_64x8.sv
// ---------------------------------------------------------------------------
// user_mem_64x8
// 64-bit storage (8 words x 8 bits) written and read through mprj_io pads.
// Ports:
//   wb_clk_i : block clock
//   wb_rst_i : synchronous active-high reset (clears synchroniser, memory,
//              read data and read-valid)
//   pads     : pad bundle (slave side)
//              io_in[0]=rd_en, io_in[3]=wr_en, io_in[7:5]=addr,
//              io_in[15:8]=wdata; io_out[23:16]=rdata, io_out[24]=rvalid;
//              io_oeb[24:16]=0, every other io_oeb bit 1.
// All pad inputs are synchronised before use; outputs are registered only.
// ---------------------------------------------------------------------------
module user_mem_64x8
    import user_mem_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGE
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    user_mem_64x8_if.slave  pads
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int SYNC_W = DATA_W + ADDR_W + 2;

    // -----------------------------------------------------------------------
    // Pad synchroniser: {wdata, addr, wr_en, rd_en}
    // -----------------------------------------------------------------------
    logic [SYNC_W-1:0] sync_d;
    logic [SYNC_W-1:0] sync_q;

    assign sync_d = {pads.io_in[DATA_LSB +: DATA_W],
                     pads.io_in[ADDR_LSB +: ADDR_W],
                     pads.io_in[WR_EN_PIN],
                     pads.io_in[RD_EN_PIN]};

    pad_sync #(
        .WIDTH  (SYNC_W),
        .STAGES (SYNC_STAGES)
    ) u_pad_sync (
        .clk  (wb_clk_i),
        .srst (wb_rst_i),
        .d    (sync_d),
        .q    (sync_q)
    );

    logic              rd_s;
    logic              wr_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s;

    assign rd_s    = sync_q[0];
    assign wr_s    = sync_q[1];
    assign addr_s  = sync_q[2 +: ADDR_W];
    assign wdata_s = sync_q[2 + ADDR_W +: DATA_W];

    // Pad inputs this block does not use; folded into one named sink.
    logic unused_pads;
    assign unused_pads = ^{pads.io_in[PAD_W-1:DATA_LSB + DATA_W],
                           pads.io_in[WR_EN_PIN + 1 +: ADDR_LSB - WR_EN_PIN - 1],
                           pads.io_in[RD_EN_PIN + 1 +: WR_EN_PIN - RD_EN_PIN - 1]};

    // -----------------------------------------------------------------------
    // Operation decode
    // -----------------------------------------------------------------------
    op_t op_cur;

    always_comb begin
        op_cur = decode_op(rd_s, wr_s);
    end

    // -----------------------------------------------------------------------
    // Memory array. Reset must clear every word, so this stays in flops
    // rather than a RAM macro; at 64 bits that is the natural mapping anyway.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] mem_reg [DEPTH];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (op_cur == OP_WRITE) begin
            mem_reg[addr_s] <= wdata_s;
        end
    end

    // -----------------------------------------------------------------------
    // Read data / read valid
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] rdata_reg;
    logic [DATA_W-1:0] rdata_next;
    logic              rvalid_reg;
    logic              rvalid_next;

    always_comb begin
        rdata_next  = rdata_reg;
        rvalid_next = rvalid_reg;
        case (op_cur)
            OP_WRITE: begin
                rvalid_next = 1'b0;
            end
            OP_READ: begin
                rdata_next  = mem_reg[addr_s];
                rvalid_next = 1'b1;
            end
            OP_ILLEGAL: begin
                rvalid_next = 1'b0;
            end
            default: begin
                // idle: everything holds, including rvalid
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            rdata_reg  <= rdata_next;
            rvalid_reg <= rvalid_next;
        end
    end

    // -----------------------------------------------------------------------
    // Pad outputs
    // -----------------------------------------------------------------------
    logic [PAD_W-1:0] pad_out;
    logic [PAD_W-1:0] pad_oeb;

    always_comb begin
        pad_out                          = '0;
        pad_out[RDATA_LSB +: DATA_W]     = rdata_reg;
        pad_out[RVALID_PIN]              = rvalid_reg;
    end

    // Only the rdata/rvalid pads are driven; every other pad stays an input.
    generate
        for (genvar gi = 0; gi < PAD_W; gi++) begin : g_oeb
            if (gi >= RDATA_LSB && gi <= RVALID_PIN) begin : g_drive
                assign pad_oeb[gi] = 1'b0;
            end else begin : g_hiz
                assign pad_oeb[gi] = 1'b1;
            end
        end
    endgenerate

    assign pads.io_out = pad_out;
    assign pads.io_oeb = pad_oeb;

endmodule

// File: tb/tb_user_mem_64x8.sv
// ---------------------------------------------------------------------------
// tb_user_mem_64x8
// Scoreboard bench for user_mem_64x8. The stimulus task drives the pads for
// one clock and advances a reference model; the model's post-edge output is
// queued and a monitor on the falling edge pops and compares it against the
// pads. Directed scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_user_mem_64x8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    user_mem_64x8_if pads_if ();

    user_mem_64x8 dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .pads     (pads_if)
    );

    localparam logic [37:0] OEB_EXP = 38'h3FFE00FFFF;

    typedef struct {
        logic [7:0] rdata;
        logic       rvalid;
    } exp_t;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [2:0] addr;
        logic [7:0] data;
    } pad_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cycle  = 0;

    // Reference model: memory contents, outputs, and the pad values still
    // travelling through the two-flop synchroniser (oldest first).
    logic [7:0] ref_mem [8];
    logic [7:0] ref_rdata;
    logic       ref_rvalid;
    pad_t       flight_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: rst, rd_en, wr_en, addr, wdata.
    task automatic cyc(input logic r, input logic rd, input logic wr,
                       input logic [2:0] a, input logic [7:0] d);
        logic [63:0] rnd;
        logic [37:0] v;
        pad_t        cur;
        pad_t        eff;
        pad_t        zero;
        exp_t        e;
        rnd = {$urandom, $urandom};
        v   = rnd[37:0];          // unused pad bits carry random noise
        v[0]    = rd;
        v[3]    = wr;
        v[7:5]  = a;
        v[15:8] = d;
        rst            = r;
        pads_if.io_in  = v;

        cur  = '{rd, wr, a, d};
        zero = '{1'b0, 1'b0, 3'd0, 8'd0};
        eff  = flight_q.pop_front();  // pad value from two edges ago
        if (r) begin
            flight_q.delete();
            flight_q.push_back(zero);
            flight_q.push_back(zero);
            for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
            ref_rdata  = 8'h00;
            ref_rvalid = 1'b0;
        end else begin
            flight_q.push_back(cur);
            if (eff.wr && !eff.rd) begin
                ref_mem[eff.addr] = eff.data;
                ref_rvalid = 1'b0;
            end else if (eff.rd && !eff.wr) begin
                ref_rdata  = ref_mem[eff.addr];
                ref_rvalid = 1'b1;
            end else if (eff.rd && eff.wr) begin
                ref_rvalid = 1'b0;
            end
        end
        e.rdata  = ref_rdata;
        e.rvalid = ref_rvalid;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the pads against the scoreboard after every edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cycle++;
            $display("cycle %0d rdata=%02h rvalid=%0b (model %02h/%0b)", n_cycle,
                     pads_if.io_out[23:16], pads_if.io_out[24], e.rdata, e.rvalid);
            check("rdata", 64'(pads_if.io_out[23:16]), 64'(e.rdata));
            check("rvalid", 64'(pads_if.io_out[24]), 64'(e.rvalid));
            check("io_out_idle_bits", 64'({pads_if.io_out[37:25], pads_if.io_out[15:0]}), 64'd0);
            check("io_oeb", 64'(pads_if.io_oeb), 64'(OEB_EXP));
        end
    end

    task automatic spot(input string name, input logic [7:0] rdata, input logic rvalid);
        check({name, "_rdata"}, 64'(pads_if.io_out[23:16]), 64'(rdata));
        check({name, "_rvalid"}, 64'(pads_if.io_out[24]), 64'(rvalid));
    endtask

    initial begin
        logic [7:0] wv;
        int         seg_len;
        int         kind;
        pads_if.io_in = '0;
        flight_q.push_back('{1'b0, 1'b0, 3'd0, 8'd0});
        flight_q.push_back('{1'b0, 1'b0, 3'd0, 8'd0});

        // Reset and power-up
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        spot("reset", 8'h00, 1'b0);
        check("reset_oeb", 64'(pads_if.io_oeb), 64'(OEB_EXP));

        // Write then read
        repeat (20) cyc(1'b0, 1'b0, 1'b1, 3'd1, 8'hFA);
        repeat (20) cyc(1'b0, 1'b0, 1'b1, 3'd3, 8'hEA);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 3'd1, 8'h6A);
        spot("read_before_latency", 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 3'd1, 8'h6A);
        spot("read_addr1", 8'hFA, 1'b1);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 3'd1, 8'h6A);
        spot("read_addr1_held", 8'hFA, 1'b1);

        // Read tracking 1 -> 3, then unwritten address 0
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 3'd3, 8'h00);
        spot("track_edge2", 8'hFA, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 3'd3, 8'h00);
        spot("track_edge3", 8'hEA, 1'b1);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
        spot("read_addr0", 8'h00, 1'b1);

        // Illegal op holds rdata, clears rvalid, leaves memory untouched
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 3'd3, 8'h00);
        repeat (4) cyc(1'b0, 1'b1, 1'b1, 3'd1, 8'h55);
        spot("illegal", 8'hEA, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 3'd1, 8'h00);
        spot("after_illegal", 8'hFA, 1'b1);

        // Idle keeps rvalid
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 3'd2, 8'h00);
        spot("idle_hold", 8'hFA, 1'b1);

        // Reset mid-write of 0x11 to address 5
        cyc(1'b0, 1'b0, 1'b1, 3'd5, 8'h11);
        cyc(1'b1, 1'b0, 1'b1, 3'd5, 8'h11);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        spot("after_reset", 8'h00, 1'b0);
        for (int a = 0; a < 8; a++) begin
            repeat (3) cyc(1'b0, 1'b1, 1'b0, 3'(a), 8'h00);
            spot("post_reset_read", 8'h00, 1'b1);
        end

        // Wrap and full coverage
        for (int a = 0; a < 8; a++) begin
            wv = 8'(a * 8'h11) ^ 8'hFF;
            repeat (3) cyc(1'b0, 1'b0, 1'b1, 3'(a), wv);
        end
        for (int a = 0; a < 8; a++) begin
            wv = 8'(a * 8'h11) ^ 8'hFF;
            repeat (3) cyc(1'b0, 1'b1, 1'b0, 3'(a), 8'h00);
            spot("fill_readback", wv, 1'b1);
        end

        // Randomized traffic
        for (int s = 0; s < 80; s++) begin
            seg_len = int'($urandom_range(1, 6));
            kind    = int'($urandom_range(0, 19));
            if (kind == 0) begin
                cyc(1'b1, 1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom));
            end else begin
                logic       rd;
                logic       wr;
                logic [2:0] a;
                logic [7:0] d;
                rd = (kind >= 10);
                wr = (kind >= 2 && kind < 10) || (kind == 1);
                if (kind == 1) rd = 1'b1;            // illegal
                if (kind >= 18) begin rd = 1'b0; wr = 1'b0; end  // idle
                a = 3'($urandom);
                d = 8'($urandom);
                repeat (seg_len) cyc(1'b0, rd, wr, a, d);
            end
        end

        repeat (3) cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
